// File: rtl/ghost_chase_ctrl.sv
// Ghost chase controller: picks a movement direction toward (or away from) pacman
// once per DECISION_FRAMES frames and steers around walls it has just hit.
module ghost_chase_ctrl #(
  parameter int unsigned DECISION_FRAMES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              playGame,
  input  logic              collision,
  input  logic              frightened,
  input  logic signed [10:0] pacmanX,
  input  logic signed [10:0] pacmanY,
  input  logic signed [10:0] ghostX,
  input  logic signed [10:0] ghostY,
  output logic              Y_up_key,
  output logic              Y_down_key,
  output logic              X_right_key,
  output logic              X_left_key,
  output logic [1:0]        ghost_direction
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 12;
  localparam int unsigned KW = 4;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_DECIDE,
    S_HOLD,
    S_BLOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [KW-1:0]   keys_q, keys_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            blocked_q, blocked_d;
  logic [1:0]      blocked_dir_q, blocked_dir_d;

  logic signed [DW-1:0] dx_raw, dy_raw, dx, dy;
  logic [DW-1:0]        adx, ady;
  logic                 x_primary;
  logic [1:0]           x_dir, y_dir, prim_dir, sec_dir, new_dir;
  logic [KW-1:0]        new_keys;

  // Direction decision; 12-bit deltas cannot overflow for 11-bit operands
  always_comb begin
    dx_raw    = DW'(pacmanX) - DW'(ghostX);
    dy_raw    = DW'(pacmanY) - DW'(ghostY);
    dx        = frightened ? -dx_raw : dx_raw;
    dy        = frightened ? -dy_raw : dy_raw;
    adx       = dx[DW-1] ? DW'(-dx) : DW'(dx);
    ady       = dy[DW-1] ? DW'(-dy) : DW'(dy);
    x_primary = (adx >= ady);
    x_dir     = dx[DW-1] ? DIR_LEFT : DIR_RIGHT;
    y_dir     = dy[DW-1] ? DIR_UP : DIR_DOWN;
    prim_dir  = x_primary ? x_dir : y_dir;
    sec_dir   = x_primary ? y_dir : x_dir;
    if (dx == '0 && dy == '0) begin
      new_dir = dir_q;
    end else if (blocked_q && prim_dir == blocked_dir_q) begin
      new_dir = sec_dir;
    end else begin
      new_dir = prim_dir;
    end
    new_keys = KW'(4'b0001 << new_dir);
  end

  // Next-state logic; playGame low dominates collision, which dominates startOfFrame
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    keys_d        = keys_q;
    cnt_d         = cnt_q;
    blocked_d     = blocked_q;
    blocked_dir_d = blocked_dir_q;
    if (state_q != S_IDLE && !playGame) begin
      state_d = S_IDLE;
      keys_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          keys_d    = '0;
          blocked_d = 1'b0;
          if (playGame) state_d = S_WAIT_SOF;
        end
        S_WAIT_SOF: begin
          keys_d = '0;
          if (startOfFrame) state_d = S_DECIDE;
        end
        S_DECIDE: begin
          dir_d     = new_dir;
          keys_d    = new_keys;
          cnt_d     = CW'(DECISION_FRAMES);
          blocked_d = 1'b0;
          state_d   = S_HOLD;
        end
        S_HOLD: begin
          if (collision) begin
            blocked_dir_d = dir_q;
            blocked_d     = 1'b1;
            keys_d        = '0;
            state_d       = S_BLOCKED;
          end else if (startOfFrame) begin
            if (cnt_q == CW'(1)) begin
              state_d = S_DECIDE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        S_BLOCKED: begin
          keys_d = '0;
          if (startOfFrame) state_d = S_DECIDE;
        end
        default: begin
          state_d = S_IDLE;
          keys_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      dir_q         <= DIR_RIGHT;
      keys_q        <= '0;
      cnt_q         <= '0;
      blocked_q     <= 1'b0;
      blocked_dir_q <= DIR_DOWN;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      keys_q        <= keys_d;
      cnt_q         <= cnt_d;
      blocked_q     <= blocked_d;
      blocked_dir_q <= blocked_dir_d;
    end
  end

  assign Y_down_key      = keys_q[0];
  assign X_right_key     = keys_q[1];
  assign X_left_key      = keys_q[2];
  assign Y_up_key        = keys_q[3];
  assign ghost_direction = dir_q;

endmodule
